// File: rtl/spi_cmd_sequencer_if.sv
// SPI byte-level handshake between the SPI slave shifter and the command sequencer.
// The master side is the shifter (or a bench standing in for it).
interface spi_cmd_sequencer_if;
    logic       cs_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_load;
    logic [7:0] tx_data;

    modport master (output cs_n, output rx_valid, output rx_data,
                    input  tx_load, input tx_data);
    modport slave  (input  cs_n, input rx_valid, input rx_data,
                    output tx_load, output tx_data);
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Three-byte SPI command decoder driving contactor, shutdown and soft-reset controls,
// with per-channel feedback supervision that latches a timeout error.
module spi_cmd_sequencer #(
    parameter int NUM_CONTACTORS = 4,
    parameter int FB_TIMEOUT     = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    spi_cmd_sequencer_if.slave            bus,
    input  logic [2*NUM_CONTACTORS-1:0]   feedback,
    input  logic [1:0]                    thermal_shutdown,
    output logic [NUM_CONTACTORS-1:0]     contactor_cmd,
    output logic                          shutdown_req,
    output logic                          pg_shutdown,
    output logic                          soft_reset
);
    localparam int          CW   = $clog2(FB_TIMEOUT + 1);
    localparam int          IW   = (NUM_CONTACTORS > 1) ? $clog2(NUM_CONTACTORS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(FB_TIMEOUT);
    localparam logic [8:0]  NC9  = 9'(NUM_CONTACTORS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IDX  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]                state;
    logic                      armed;
    logic [7:0]                cmd;
    logic [IW-1:0]             ix_q;
    logic                      idx_ok_q;
    logic [NUM_CONTACTORS-1:0] cmd_store;
    logic                      fb_err;
    logic                      inv_req;
    logic [CW-1:0]             cnt [NUM_CONTACTORS];

    logic                      rx_byte, cmd_byte, idx_byte, data_byte;
    logic                      cmd_known, idx_ok, idx_checked;
    logic [IW-1:0]             rx_ix;
    logic [7:0]                rd_val;
    logic [NUM_CONTACTORS-1:0] match;
    logic                      to_set, inv_set, clear_err;

    // Any latched fault or shutdown request overrides the stored contactor settings.
    assign contactor_cmd = (fb_err || shutdown_req || pg_shutdown) ? '0 : cmd_store;

    always_comb begin
        rx_byte     = bus.rx_valid && !bus.cs_n;
        cmd_byte    = rx_byte && (state == S_IDLE) && armed;
        idx_byte    = rx_byte && (state == S_IDX);
        data_byte   = rx_byte && (state == S_DATA);
        cmd_known   = (bus.rx_data[6:0] >= 7'd1) && (bus.rx_data[6:0] <= 7'd4);
        idx_ok      = {1'b0, bus.rx_data} < NC9;
        rx_ix       = bus.rx_data[IW-1:0];
        idx_checked = (cmd == 8'h01) || (cmd == 8'h02) || (cmd == 8'h81);
        inv_set     = (cmd_byte && !cmd_known) || (idx_byte && idx_checked && !idx_ok);
        clear_err   = data_byte && (cmd == 8'h82) && bus.rx_data[1];
    end

    always_comb begin
        rd_val = 8'h00;
        case (cmd)
            8'h01: if (idx_ok) rd_val = {7'b0, contactor_cmd[rx_ix]};
            8'h02: if (idx_ok) rd_val = {6'b0, feedback[{rx_ix, 1'b0} +: 2]};
            8'h03: rd_val = {fb_err, inv_req, thermal_shutdown, 4'b0};
            8'h04: rd_val = {6'b0, pg_shutdown, shutdown_req};
            default: rd_val = 8'h00;
        endcase
    end

    always_comb begin
        match  = '0;
        to_set = 1'b0;
        for (int i = 0; i < NUM_CONTACTORS; i++) begin
            match[i] = (feedback[2*i +: 2] == {2{contactor_cmd[i]}});
            if (cnt[i] == CMAX) to_set = 1'b1;
        end
    end

    // armed stays low after reset until cs_n is seen high, so a frame cut by reset
    // cannot resume with its trailing bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            cmd      <= 8'h00;
            ix_q     <= '0;
            idx_ok_q <= 1'b0;
        end else if (bus.cs_n) begin
            state <= S_IDLE;
            armed <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (cmd_byte) begin
                    cmd   <= bus.rx_data;
                    state <= cmd_known ? S_IDX : S_DONE;
                end
                S_IDX: if (bus.rx_valid) begin
                    ix_q     <= rx_ix;
                    idx_ok_q <= idx_ok;
                    state    <= S_DATA;
                end
                S_DATA: if (bus.rx_valid) state <= S_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.tx_load  <= 1'b0;
            bus.tx_data  <= 8'h00;
            soft_reset   <= 1'b0;
            cmd_store    <= '0;
            shutdown_req <= 1'b0;
            pg_shutdown  <= 1'b0;
        end else begin
            bus.tx_load <= 1'b0;
            soft_reset  <= 1'b0;
            if (idx_byte && !cmd[7]) begin
                bus.tx_load <= 1'b1;
                bus.tx_data <= rd_val;
            end
            if (data_byte) begin
                case (cmd)
                    8'h81: if (idx_ok_q) cmd_store[ix_q] <= bus.rx_data[0];
                    8'h82: soft_reset   <= bus.rx_data[0];
                    8'h83: shutdown_req <= bus.rx_data[0];
                    8'h84: pg_shutdown  <= bus.rx_data[0];
                    default: ;
                endcase
            end
        end
    end

    // Raising an error wins over a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_err  <= 1'b0;
            inv_req <= 1'b0;
            for (int i = 0; i < NUM_CONTACTORS; i++) cnt[i] <= '0;
        end else begin
            if (to_set)         fb_err <= 1'b1;
            else if (clear_err) fb_err <= 1'b0;
            if (inv_set)        inv_req <= 1'b1;
            else if (clear_err) inv_req <= 1'b0;
            for (int i = 0; i < NUM_CONTACTORS; i++) begin
                if (match[i])          cnt[i] <= '0;
                else if (cnt[i] != CMAX) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed and randomized frame checks of spi_cmd_sequencer against a register-level
// model of the command set, contactor masking and error flags.
module tb_spi_cmd_sequencer;
    localparam int N = 4;
    localparam int T = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [2*N-1:0] feedback;
    logic [1:0]     thermal = 2'b00;
    logic [N-1:0]   contactor_cmd;
    logic           shutdown_req, pg_shutdown, soft_reset;
    logic [N-1:0]   brk = '0;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] m_store = '0;
    logic         m_shut = 1'b0, m_pg = 1'b0, m_fte = 1'b0, m_inv = 1'b0;

    spi_cmd_sequencer_if bus();

    spi_cmd_sequencer #(.NUM_CONTACTORS(N), .FB_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .bus(bus), .feedback(feedback),
        .thermal_shutdown(thermal), .contactor_cmd(contactor_cmd),
        .shutdown_req(shutdown_req), .pg_shutdown(pg_shutdown), .soft_reset(soft_reset)
    );

    always #5 clk = ~clk;

    // Healthy contactors echo their command on both feedback poles; brk forces an open.
    always_comb begin
        feedback = '0;
        for (int i = 0; i < N; i++)
            feedback[2*i +: 2] = brk[i] ? 2'b00 : {2{contactor_cmd[i]}};
    end

    function automatic logic [N-1:0] m_cc();
        return (m_fte || m_shut || m_pg) ? '0 : m_store;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_cc"}, 32'(contactor_cmd), 32'(m_cc()));
        chk({tag, "_shut"}, 32'(shutdown_req), 32'(m_shut));
        chk({tag, "_pg"}, 32'(pg_shutdown), 32'(m_pg));
    endtask

    task automatic do_frame(input logic [7:0] c, input logic [7:0] i, input logic [7:0] d, input int nb);
        logic         valid, ok, exp_pulse, exp_soft;
        logic [7:0]   exp_tx;
        logic [N-1:0] cc;
        logic [1:0]   ix;
        valid = (c[6:0] >= 7'd1) && (c[6:0] <= 7'd4);
        ok    = (i < 8'(N));
        ix    = i[1:0];
        bus.cs_n = 1'b0;
        tick();
        send_byte(c);
        if (!valid) m_inv = 1'b1;
        chk("tx_cmd", 32'(bus.tx_load), 0);
        if (nb >= 2) begin
            tick();
            cc        = m_cc();
            exp_pulse = valid && !c[7];
            exp_tx    = 8'h00;
            case (c)
                8'h01: if (ok) exp_tx = {7'b0, cc[ix]};
                8'h02: if (ok) exp_tx = {6'b0, cc[ix], cc[ix]};
                8'h03: exp_tx = {m_fte, m_inv, thermal, 4'b0};
                8'h04: exp_tx = {6'b0, m_pg, m_shut};
                default: exp_tx = 8'h00;
            endcase
            if (valid && (c == 8'h01 || c == 8'h02 || c == 8'h81) && !ok) m_inv = 1'b1;
            send_byte(i);
            chk("tx_idx_pulse", 32'(bus.tx_load), 32'(exp_pulse));
            if (exp_pulse) chk("tx_idx_data", 32'(bus.tx_data), 32'(exp_tx));
        end
        if (nb >= 3) begin
            tick();
            exp_soft = 1'b0;
            if (valid) begin
                case (c)
                    8'h81: if (ok) m_store[ix] = d[0];
                    8'h82: begin
                        exp_soft = d[0];
                        if (d[1]) begin m_inv = 1'b0; m_fte = 1'b0; end
                    end
                    8'h83: m_shut = d[0];
                    8'h84: m_pg = d[0];
                    default: ;
                endcase
            end
            send_byte(d);
            chk("tx_b2", 32'(bus.tx_load), 0);
            chk("soft_pulse", 32'(soft_reset), 32'(exp_soft));
            chk_outs("b2");
            tick();
            chk("soft_end", 32'(soft_reset), 0);
        end
        bus.cs_n = 1'b1;
        tick();
        tick();
        chk_outs("post");
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] rc, ri, rd;
        bus.cs_n = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cc", 32'(contactor_cmd), 0);
        chk("rst_shut", 32'(shutdown_req), 0);
        chk("rst_pg", 32'(pg_shutdown), 0);
        chk("rst_txl", 32'(bus.tx_load), 0);
        chk("rst_txd", 32'(bus.tx_data), 0);
        chk("rst_soft", 32'(soft_reset), 0);
        rst = 1'b0;
        tick();

        // Contactor 2 closes with matching feedback; no timeout develops.
        do_frame(8'h81, 8'h02, 8'h01, 3);
        chk("cc2", 32'(contactor_cmd[2]), 1);
        repeat (T + 10) tick();
        do_frame(8'h03, 8'h00, 8'h00, 3);

        // Channel 0 closed with open feedback: timeout forces everything open.
        do_frame(8'h81, 8'h00, 8'h01, 3);
        brk = 4'b0001;
        n = 0;
        while (contactor_cmd[0] !== 1'b0 && n < T + 20) begin tick(); n++; end
        chk("to_drop", 32'(contactor_cmd), 0);
        chk("to_latency", 32'(n >= T && n <= T + 2), 1);
        m_fte = 1'b1;
        brk = '0;
        do_frame(8'h03, 8'h00, 8'h00, 3);
        chk("status_to", 32'(bus.tx_data), 32'h80);

        do_frame(8'h82, 8'h00, 8'h02, 3);
        do_frame(8'h82, 8'h00, 8'h01, 3);

        // Unknown command, then out-of-range read index.
        do_frame(8'h55, 8'h03, 8'h00, 3);
        do_frame(8'h03, 8'h00, 8'h00, 3);
        chk("status_inv", 32'(bus.tx_data), 32'h40);
        do_frame(8'h01, 8'h07, 8'h00, 3);
        do_frame(8'h82, 8'h00, 8'h02, 3);

        // Truncated shutdown write is discarded; the full one masks all contactors.
        do_frame(8'h83, 8'h00, 8'h01, 2);
        do_frame(8'h83, 8'h00, 8'h01, 3);
        do_frame(8'h83, 8'h00, 8'h00, 3);

        thermal = 2'b11;
        do_frame(8'h03, 8'h00, 8'h00, 3);
        thermal = 2'b00;

        // Reset in the middle of a PG shutdown write.
        bus.cs_n = 1'b0;
        tick();
        send_byte(8'h84); tick();
        send_byte(8'h00); tick();
        rst = 1'b1;
        #2;
        m_store = '0; m_shut = 1'b0; m_pg = 1'b0; m_fte = 1'b0; m_inv = 1'b0;
        chk("mid_cc", 32'(contactor_cmd), 0);
        chk("mid_pg", 32'(pg_shutdown), 0);
        chk("mid_txd", 32'(bus.tx_data), 0);
        tick();
        rst = 1'b0;
        tick();
        send_byte(8'h84); tick();
        send_byte(8'h00); tick();
        send_byte(8'h01);
        chk("mid_noresume_pg", 32'(pg_shutdown), 0);
        chk("mid_noresume_txl", 32'(bus.tx_load), 0);
        bus.cs_n = 1'b1;
        tick(); tick();
        do_frame(8'h84, 8'h00, 8'h01, 3);
        do_frame(8'h84, 8'h00, 8'h00, 3);

        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(0, 9);
            if (n < 4)       rc = 8'(n + 1);
            else if (n < 8)  rc = 8'h80 | 8'(n - 3);
            else if (n == 8) rc = 8'($urandom);
            else             rc = 8'h03;
            ri = 8'($urandom_range(0, 5));
            rd = 8'($urandom);
            thermal = 2'($urandom);
            do_frame(rc, ri, rd, ($urandom_range(0, 7) == 0) ? 2 : 3);
        end
        thermal = 2'b00;
        do_frame(8'h03, 8'h00, 8'h00, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_CONTACTORS, default 4, number of contactor channels (1..16).
REQ-002 SHALL have parameter FB_TIMEOUT, default 1000, clk cycles of feedback mismatch before timeout error (>=2).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cs_n  input  1  SPI chip select, already synchronised; high = no frame.
REQ-006 SHALL have port rx_valid  input  1  one-cycle pulse, full byte received from SPI slave.
REQ-007 SHALL have port rx_data  input  8  received byte, valid with rx_valid.
REQ-008 SHALL have port tx_load  output  1  one-cycle pulse, load tx_data into SPI shifter.
REQ-009 SHALL have port tx_data  output  8  response byte.
REQ-010 SHALL have port feedback  input  2*NUM_CONTACTORS  {plus,minus} feedback per channel, channel i at [2i+1:2i].
REQ-011 SHALL have port thermal_shutdown  input  2  thermal flags.
REQ-012 SHALL have port contactor_cmd  output  NUM_CONTACTORS  contactor close command per channel.
REQ-013 SHALL have port shutdown_req  output  1  latched shutdown request.
REQ-014 SHALL have port pg_shutdown  output  1  latched direct PG shutdown.
REQ-015 SHALL have port soft_reset  output  1  one-cycle pulse on control reset_req.

Function
REQ-016 SHALL frame as: byte0 command, byte1 index, byte2 data (write) / reply slot (read); commands 0x01-0x04 read, 0x81-0x84 write.
REQ-017 SHALL use FSM IDLE -> IDX (cmd byte) -> DATA (index byte) -> DONE (byte2); DONE -> IDLE on cs_n high.
REQ-018 SHALL return to IDLE, discarding any partial write, whenever cs_n is high in any state.
REQ-019 SHALL on unknown command byte set sticky invalid_request and go to DONE; bytes ignored until cs_n high.
REQ-020 SHALL for read commands pulse tx_load with tx_data the cycle after the index byte's rx_valid.
REQ-021 SHALL read: 0x01 -> {7'b0,contactor_cmd[idx]}; 0x02 -> {6'b0,feedback[idx]}; 0x03 -> status; 0x04 -> {6'b0,pg_shutdown,shutdown_req}.
REQ-022 SHALL form status as {feedback_timeout_error, invalid_request, thermal_shutdown[1:0], 4'b0}.
REQ-023 SHALL for 0x01/0x02/0x81 with index >= NUM_CONTACTORS set invalid_request; reads return 0x00, writes ignored.
REQ-024 SHALL apply writes the cycle after byte2 rx_valid: 0x81 contactor_cmd[idx]=data[0]; 0x83 shutdown_req=data[0]; 0x84 pg_shutdown=data[0]; 0x82 control.
REQ-025 SHALL on control write: data[0] -> soft_reset one-cycle pulse; data[1] -> clear feedback_timeout_error and invalid_request.
REQ-026 SHALL give set priority over clear when an error is raised the same cycle as clear_errors.
REQ-027 SHALL keep per-channel counter: reset to 0 when feedback[i]=={cmd_i,cmd_i}, else increment, saturating at FB_TIMEOUT.
REQ-028 SHALL set sticky feedback_timeout_error when any counter reaches FB_TIMEOUT.
REQ-029 SHALL force all contactor_cmd to 0 while feedback_timeout_error, shutdown_req or pg_shutdown is set; 0x81 writes stored but masked.
REQ-030 SHALL ignore rx_valid in DONE and tx_load SHALL never pulse for write commands.

Reset
REQ-031 SHALL on rst: FSM IDLE; contactor_cmd, shutdown_req, pg_shutdown, soft_reset, tx_load = 0; tx_data = 0x00; errors and counters cleared.
REQ-032 SHALL treat rst mid-frame as abort: no write applied; next frame requires cs_n high then low.

Verification
REQ-033 SHALL cover: frame 0x81,0x02,0x01 -> contactor_cmd[2]=1 one cycle after byte2; feedback[5:4]=2'b11 keeps error 0.
REQ-034 SHALL cover: contactor_cmd[0]=1, feedback[1:0]=00 for FB_TIMEOUT cycles -> feedback_timeout_error=1, contactor_cmd=0; read 0x03 -> 0x80.
REQ-035 SHALL cover: frame 0x82,0x00,0x02 -> errors cleared; 0x82,0x00,0x01 -> soft_reset high exactly one cycle.
REQ-036 SHALL cover: cmd 0x55 -> invalid_request=1, no tx_load; index 0x07 with NUM_CONTACTORS=4 read 0x01 -> tx_data 0x00, invalid set.
REQ-037 SHALL cover: cs_n high after 0x83,0x00 (no byte2) -> shutdown_req unchanged 0; full 0x83,0x00,0x01 -> shutdown_req=1, all contactor_cmd=0.
REQ-038 SHALL cover: rst asserted during DATA of 0x84 frame -> pg_shutdown=0, FSM IDLE, all outputs at reset values.
